// File: rtl/multi_slave_seq_pkg.sv
// rtl/multi_slave_seq_pkg.sv - state codes and mask helper for the multi-slave sequencer
package multi_slave_seq_pkg;

  localparam int SEQ_STATE_W    = 3;
  localparam int SEQ_MAX_SLAVES = 16;

  localparam logic [SEQ_STATE_W-1:0] SEQ_IDLE     = 3'd0;
  localparam logic [SEQ_STATE_W-1:0] SEQ_LAUNCH   = 3'd1;
  localparam logic [SEQ_STATE_W-1:0] SEQ_WAIT     = 3'd2;
  localparam logic [SEQ_STATE_W-1:0] SEQ_RETRY    = 3'd3;
  localparam logic [SEQ_STATE_W-1:0] SEQ_COMPLETE = 3'd4;
  localparam logic [SEQ_STATE_W-1:0] SEQ_ERROR    = 3'd5;

  // Two's-complement trick isolates the lowest set bit as a one-hot mask.
  function automatic logic [SEQ_MAX_SLAVES-1:0] lowest_set(input logic [SEQ_MAX_SLAVES-1:0] mask);
    return mask & (~mask + 16'd1);
  endfunction

endpackage

// File: rtl/seq_timeout_timer.sv
// rtl/seq_timeout_timer.sv - saturating per-launch wait counter with expiry flag
module seq_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] SAT  = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != SAT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/multi_slave_sequencer.sv
// rtl/multi_slave_sequencer.sv - master FSM launching and supervising NUM_SLAVES slave FSMs
module multi_slave_sequencer
  import multi_slave_seq_pkg::*;
#(
  parameter int NUM_SLAVES     = 4,
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int MAX_RETRY      = 2,
  parameter int PARALLEL       = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NUM_SLAVES-1:0]  chan_en,
  output logic [NUM_SLAVES-1:0]  slv_start,
  input  logic [NUM_SLAVES-1:0]  slv_busy,
  input  logic [NUM_SLAVES-1:0]  slv_done,
  output logic [SEQ_STATE_W-1:0] state,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [NUM_SLAVES-1:0]  err_mask
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

  logic [SEQ_STATE_W-1:0] state_q, state_d;
  logic [NUM_SLAVES-1:0]  pending_q, pending_d;
  logic [NUM_SLAVES-1:0]  outstanding_q, outstanding_d;
  logic [NUM_SLAVES-1:0]  slv_start_q, slv_start_d;
  logic [NUM_SLAVES-1:0]  err_mask_q, err_mask_d;
  logic [RW-1:0]          retry_q, retry_d;
  logic                   busy_q, busy_d;
  logic                   error_q, error_d;
  logic                   done_q;

  logic [NUM_SLAVES-1:0]  group, completing, next_out, next_pend;
  logic                   timer_clr, timer_en, expired;

  // A retry relaunches from pending, which still holds exactly the unfinished channels of the group.
  assign group      = (PARALLEL != 0) ? pending_q
                                      : NUM_SLAVES'(lowest_set(SEQ_MAX_SLAVES'(pending_q)));
  assign completing = outstanding_q & slv_done & ~slv_busy;
  assign next_out   = outstanding_q & ~completing;
  assign next_pend  = pending_q & ~completing;
  assign timer_clr  = (state_q == SEQ_LAUNCH);
  assign timer_en   = (state_q == SEQ_WAIT);

  seq_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (expired)
  );

  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    outstanding_d = outstanding_q;
    slv_start_d   = '0;
    retry_d       = retry_q;
    busy_d        = busy_q;
    error_d       = error_q;
    err_mask_d    = err_mask_q;
    case (state_q)
      SEQ_IDLE: begin
        if (start) begin
          error_d    = 1'b0;
          err_mask_d = '0;
          if (chan_en != '0) begin
            pending_d = chan_en;
            busy_d    = 1'b1;
            retry_d   = '0;
            state_d   = SEQ_LAUNCH;
          end else begin
            state_d = SEQ_COMPLETE;
          end
        end
      end
      SEQ_LAUNCH: begin
        slv_start_d   = group;
        outstanding_d = group;
        state_d       = SEQ_WAIT;
      end
      SEQ_WAIT: begin
        outstanding_d = next_out;
        pending_d     = next_pend;
        // Completion beats a simultaneous timeout, so only next_out can time out.
        if (next_out == '0) begin
          if (next_pend != '0) begin
            retry_d = '0;
            state_d = SEQ_LAUNCH;
          end else begin
            state_d = SEQ_COMPLETE;
          end
        end else if (expired) begin
          if (retry_q < RETRY_LIM) begin
            retry_d = retry_q + RW'(1);
            state_d = SEQ_RETRY;
          end else begin
            err_mask_d = next_out;
            state_d    = SEQ_ERROR;
          end
        end
      end
      SEQ_RETRY: state_d = SEQ_LAUNCH;
      SEQ_COMPLETE: begin
        busy_d  = 1'b0;
        state_d = SEQ_IDLE;
      end
      SEQ_ERROR: begin
        error_d = 1'b1;
        busy_d  = 1'b0;
        state_d = SEQ_IDLE;
      end
      default: state_d = SEQ_ERROR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= SEQ_IDLE;
      pending_q     <= '0;
      outstanding_q <= '0;
      slv_start_q   <= '0;
      retry_q       <= '0;
      busy_q        <= 1'b0;
      error_q       <= 1'b0;
      err_mask_q    <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
      slv_start_q   <= slv_start_d;
      retry_q       <= retry_d;
      busy_q        <= busy_d;
      error_q       <= error_d;
      err_mask_q    <= err_mask_d;
      done_q        <= (state_d == SEQ_COMPLETE);
    end
  end

  assign state     = state_q;
  assign slv_start = slv_start_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_mask  = err_mask_q;

endmodule
